// File: rtl/gpu_core_pkg.sv
// Shared types and constants for the per-core control path.
package gpu_core_pkg;

  // Sequencer state encodings, observed by decoder, fetcher, ALUs, LSUs and PC units
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  // Per-thread LSU status as reported to the sequencer
  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

  // The decoder latches its outputs while the core sits in this state
  localparam core_state_t CORE_STATE_DECODE = CORE_DECODE;

  // An LSU holds the core in WAIT while a request is outstanding
  function automatic logic lsu_busy(input lsu_state_t s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/core_sequencer_pc_select.sv
// Combinational PC reconciliation: takes the lowest enabled thread's next PC
// and flags whether any other enabled thread wants a different one.
module pc_select #(
  parameter int THREADS  = 4,
  parameter int PC_WIDTH = 8
) (
  input  logic [THREADS-1:0]          thread_enable,
  input  logic [PC_WIDTH*THREADS-1:0] next_pc,
  output logic [PC_WIDTH-1:0]         selected_pc,
  output logic                        mismatch
);

  logic [PC_WIDTH-1:0] pc_arr [THREADS];

  generate
    for (genvar gi = 0; gi < THREADS; gi++) begin : g_unpack
      assign pc_arr[gi] = next_pc[PC_WIDTH*gi +: PC_WIDTH];
    end
  endgenerate

  // Priority select: first enabled thread from index 0 upward wins
  always_comb begin
    logic found;
    selected_pc = '0;
    found       = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (thread_enable[i] && !found) begin
        selected_pc = pc_arr[i];
        found       = 1'b1;
      end
    end
  end

  // Any enabled thread disagreeing with the selected PC means divergence
  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (thread_enable[i] && (pc_arr[i] != selected_pc)) begin
        mismatch = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Per-core control FSM: FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE
// for one block of threads, owning the shared PC and retiring the block on RET.
module core_sequencer
  import gpu_core_pkg::*;
#(
  parameter int THREADS  = 4,
  parameter int PC_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [THREADS-1:0]          thread_enable,
  input  logic                        fetch_done,
  input  logic [2*THREADS-1:0]        lsu_state,
  input  logic                        decoded_mem_read_enable,
  input  logic                        decoded_mem_write_enable,
  input  logic                        decoded_ret,
  input  logic [PC_WIDTH*THREADS-1:0] next_pc,
  output logic [2:0]                  core_state,
  output logic [PC_WIDTH-1:0]         current_pc,
  output logic                        done,
  output logic                        diverged
);

  core_state_t         state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic                diverged_reg, diverged_next;

  logic [THREADS-1:0]  thread_busy;
  logic                busy;
  logic [PC_WIDTH-1:0] selected_pc;
  logic                pc_mismatch;

  // The memory-op flags are carried for the decoder interface only: the LSU
  // status alone decides how long WAIT lasts, so a non-memory op exits at once.
  logic unused_decoded_mem;
  assign unused_decoded_mem = decoded_mem_read_enable ^ decoded_mem_write_enable;

  generate
    for (genvar gi = 0; gi < THREADS; gi++) begin : g_busy
      assign thread_busy[gi] = thread_enable[gi] &
                               lsu_busy(lsu_state_t'(lsu_state[2*gi +: 2]));
    end
  endgenerate

  assign busy = |thread_busy;

  pc_select #(
    .THREADS  (THREADS),
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_select (
    .thread_enable (thread_enable),
    .next_pc       (next_pc),
    .selected_pc   (selected_pc),
    .mismatch      (pc_mismatch)
  );

  // State, PC and sticky divergence registers; reset aborts any block in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CORE_IDLE;
      pc_reg       <= '0;
      diverged_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      diverged_reg <= diverged_next;
    end
  end

  // Next-state, PC update and divergence capture
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    diverged_next = diverged_reg;
    case (state_reg)
      CORE_IDLE: begin
        if (start) begin
          // An empty mask has nothing to run: retire without fetching
          state_next = (thread_enable != '0) ? CORE_FETCH : CORE_DONE;
        end
      end
      CORE_FETCH: begin
        if (fetch_done) state_next = CORE_DECODE;
      end
      CORE_STATE_DECODE: state_next = CORE_REQUEST;
      CORE_REQUEST:      state_next = CORE_WAIT;
      CORE_WAIT: begin
        if (!busy) state_next = CORE_EXECUTE;
      end
      CORE_EXECUTE:      state_next = CORE_UPDATE;
      CORE_UPDATE: begin
        if (decoded_ret) begin
          state_next = CORE_DONE;
        end else begin
          state_next = CORE_FETCH;
          pc_next    = selected_pc;
          if (pc_mismatch) diverged_next = 1'b1;
        end
      end
      CORE_DONE:         state_next = CORE_DONE;
      default:           state_next = CORE_IDLE;
    endcase
  end

  assign core_state = state_reg;
  assign current_pc = pc_reg;
  assign done       = (state_reg == CORE_DONE);
  assign diverged   = diverged_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: the stimulus process pushes the
// expected post-edge outputs each cycle, a monitor pops and compares them.
module tb_core_sequencer;

  localparam int THREADS  = 4;
  localparam int PC_WIDTH = 8;

  localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010,
                         S_REQUEST = 3'b011, S_WAIT = 3'b100, S_EXECUTE = 3'b101,
                         S_UPDATE = 3'b110, S_DONE = 3'b111;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic [THREADS-1:0]          thread_enable;
  logic                        fetch_done;
  logic [2*THREADS-1:0]        lsu_state;
  logic                        decoded_mem_read_enable;
  logic                        decoded_mem_write_enable;
  logic                        decoded_ret;
  logic [PC_WIDTH*THREADS-1:0] next_pc;
  logic [2:0]                  core_state;
  logic [PC_WIDTH-1:0]         current_pc;
  logic                        done;
  logic                        diverged;

  core_sequencer #(.THREADS(THREADS), .PC_WIDTH(PC_WIDTH)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .thread_enable            (thread_enable),
    .fetch_done               (fetch_done),
    .lsu_state                (lsu_state),
    .decoded_mem_read_enable  (decoded_mem_read_enable),
    .decoded_mem_write_enable (decoded_mem_write_enable),
    .decoded_ret              (decoded_ret),
    .next_pc                  (next_pc),
    .core_state               (core_state),
    .current_pc               (current_pc),
    .done                     (done),
    .diverged                 (diverged)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [2:0]  st;
    logic [7:0]  pc;
    logic        dn;
    logic        dv;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  // Monitor: one expectation per cycle, compared on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (core_state !== e.st) begin
        n_fail++;
        $display("FAIL step %0d core_state: got %b want %b", e.step, core_state, e.st);
      end
      n_tests++;
      if (current_pc !== e.pc) begin
        n_fail++;
        $display("FAIL step %0d current_pc: got %0d want %0d", e.step, current_pc, e.pc);
      end
      n_tests++;
      if (done !== e.dn) begin
        n_fail++;
        $display("FAIL step %0d done: got %b want %b", e.step, done, e.dn);
      end
      n_tests++;
      if (diverged !== e.dv) begin
        n_fail++;
        $display("FAIL step %0d diverged: got %b want %b", e.step, diverged, e.dv);
      end
      $display("[TB] step %0d state=%b pc=%0d done=%b div=%b", e.step,
               core_state, current_pc, done, diverged);
    end
  end

  // Clock one edge with the current inputs and queue the expected result
  task automatic cyc(input logic [2:0] st, input logic [7:0] pc,
                     input logic dn, input logic dv);
    exp_t e;
    @(posedge clk);
    #1;
    step_no++;
    e.step = step_no;
    e.st   = st;
    e.pc   = pc;
    e.dn   = dn;
    e.dv   = dv;
    exp_q.push_back(e);
  endtask

  task automatic set_pc(input logic [7:0] t0, input logic [7:0] t1,
                        input logic [7:0] t2, input logic [7:0] t3);
    next_pc = {t3, t2, t1, t0};
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; thread_enable = '0; fetch_done = 1'b0;
    lsu_state = '0; decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0;
    decoded_ret = 1'b0; next_pc = '0;

    // Reset state
    cyc(S_IDLE, 0, 0, 0);
    cyc(S_IDLE, 0, 0, 0);
    reset = 1'b0;
    cyc(S_IDLE, 0, 0, 0);

    // ALU instruction, fetch_done arrives on the second FETCH cycle
    thread_enable = 4'b1111; set_pc(5, 5, 5, 5); start = 1'b1;
    cyc(S_FETCH, 0, 0, 0);
    start = 1'b0;
    cyc(S_FETCH, 0, 0, 0);
    fetch_done = 1'b1;
    cyc(S_DECODE, 0, 0, 0);
    fetch_done = 1'b0;
    cyc(S_REQUEST, 0, 0, 0);
    cyc(S_WAIT, 0, 0, 0);
    cyc(S_EXECUTE, 0, 0, 0);
    cyc(S_UPDATE, 0, 0, 0);
    cyc(S_FETCH, 5, 0, 0);

    // LDR: thread 2 REQUESTING 1 cycle, WAITING 3, then DONE -> 5 WAIT cycles
    set_pc(6, 6, 6, 6); decoded_mem_read_enable = 1'b1; fetch_done = 1'b1;
    cyc(S_DECODE, 5, 0, 0);
    fetch_done = 1'b0;
    cyc(S_REQUEST, 5, 0, 0);
    cyc(S_WAIT, 5, 0, 0);
    lsu_state = 8'h01 << 4;
    cyc(S_WAIT, 5, 0, 0);
    lsu_state = 8'h02 << 4;
    cyc(S_WAIT, 5, 0, 0);
    cyc(S_WAIT, 5, 0, 0);
    cyc(S_WAIT, 5, 0, 0);
    lsu_state = 8'h03 << 4;
    cyc(S_EXECUTE, 5, 0, 0);
    lsu_state = '0; decoded_mem_read_enable = 1'b0;
    cyc(S_UPDATE, 5, 0, 0);
    cyc(S_FETCH, 6, 0, 0);

    // Divergence: thread 2 disagrees, lowest enabled thread wins
    set_pc(7, 7, 4, 7); fetch_done = 1'b1;
    cyc(S_DECODE, 6, 0, 0);
    fetch_done = 1'b0;
    cyc(S_REQUEST, 6, 0, 0);
    cyc(S_WAIT, 6, 0, 0);
    cyc(S_EXECUTE, 6, 0, 0);
    cyc(S_UPDATE, 6, 0, 0);
    cyc(S_FETCH, 7, 0, 1);
    // Agreeing instruction afterwards: diverged stays set
    set_pc(8, 8, 8, 8); fetch_done = 1'b1;
    cyc(S_DECODE, 7, 0, 1);
    fetch_done = 1'b0;
    cyc(S_REQUEST, 7, 0, 1);
    cyc(S_WAIT, 7, 0, 1);
    cyc(S_EXECUTE, 7, 0, 1);
    cyc(S_UPDATE, 7, 0, 1);
    cyc(S_FETCH, 8, 0, 1);

    // RET: PC unchanged, DONE holds and ignores start
    set_pc(9, 9, 9, 9); decoded_ret = 1'b1; fetch_done = 1'b1;
    cyc(S_DECODE, 8, 0, 1);
    fetch_done = 1'b0;
    cyc(S_REQUEST, 8, 0, 1);
    cyc(S_WAIT, 8, 0, 1);
    cyc(S_EXECUTE, 8, 0, 1);
    cyc(S_UPDATE, 8, 0, 1);
    cyc(S_DONE, 8, 1, 1);
    decoded_ret = 1'b0; start = 1'b1;
    cyc(S_DONE, 8, 1, 1);
    start = 1'b0;
    cyc(S_DONE, 8, 1, 1);
    start = 1'b1;
    cyc(S_DONE, 8, 1, 1);
    start = 1'b0;

    // Reset out of DONE
    reset = 1'b1;
    cyc(S_IDLE, 0, 0, 0);
    reset = 1'b0;

    // Disabled-thread ignore: mask 0101, thread 1 stuck WAITING with PC 9
    thread_enable = 4'b0101; set_pc(3, 9, 3, 0); lsu_state = 8'h02 << 2; start = 1'b1;
    cyc(S_FETCH, 0, 0, 0);
    start = 1'b0; fetch_done = 1'b1;
    cyc(S_DECODE, 0, 0, 0);
    fetch_done = 1'b0;
    cyc(S_REQUEST, 0, 0, 0);
    cyc(S_WAIT, 0, 0, 0);
    cyc(S_EXECUTE, 0, 0, 0);
    cyc(S_UPDATE, 0, 0, 0);
    cyc(S_FETCH, 3, 0, 0);

    // Enabled threads 0 and 2 split -> diverged, PC from thread 0
    set_pc(4, 9, 5, 0); fetch_done = 1'b1;
    cyc(S_DECODE, 3, 0, 0);
    fetch_done = 1'b0;
    cyc(S_REQUEST, 3, 0, 0);
    cyc(S_WAIT, 3, 0, 0);
    cyc(S_EXECUTE, 3, 0, 0);
    cyc(S_UPDATE, 3, 0, 0);
    cyc(S_FETCH, 4, 0, 1);

    // Reset while WAIT is held busy by thread 0
    fetch_done = 1'b1;
    cyc(S_DECODE, 4, 0, 1);
    fetch_done = 1'b0;
    cyc(S_REQUEST, 4, 0, 1);
    lsu_state = (8'h02 << 2) | 8'h02;
    cyc(S_WAIT, 4, 0, 1);
    cyc(S_WAIT, 4, 0, 1);
    reset = 1'b1;
    cyc(S_IDLE, 0, 0, 0);
    reset = 1'b0; lsu_state = '0;

    // Empty mask: straight to DONE, no FETCH
    thread_enable = 4'b0000; start = 1'b1;
    cyc(S_DONE, 0, 1, 0);
    start = 1'b0;
    cyc(S_DONE, 0, 1, 0);

    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Per-core control FSM that sequences one block of threads through the FETCH → DECODE → REQUEST → WAIT → EXECUTE → UPDATE loop.
- Drives core_state, which the instruction decoder, fetcher, ALUs, LSUs and PC units observe to know when to act.
- Owns the shared core PC. Waits on the fetcher and all enabled LSUs, and retires the block on RET.

Parameters:
THREADS, 4, threads per core (1..16)
PC_WIDTH, 8, program-counter width in bits

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  level; begin executing block at PC 0
thread_enable  in  THREADS  per-thread active mask, stable while start is high
fetch_done  in  1  fetcher has instruction valid (1-cycle pulse or level)
lsu_state  in  2*THREADS  per-thread LSU state, thread i at [2i+1:2i]; 0=IDLE 1=REQUESTING 2=WAITING 3=DONE
decoded_mem_read_enable  in  1  from decoder
decoded_mem_write_enable  in  1  from decoder
decoded_ret  in  1  from decoder
next_pc  in  PC_WIDTH*THREADS  per-thread next PC from PC units, thread i at [PC_WIDTH*(i+1)-1:PC_WIDTH*i]
core_state  out  3  current sequencer state
current_pc  out  PC_WIDTH  shared PC presented to fetcher
done  out  1  block finished
diverged  out  1  sticky: enabled threads disagreed on next PC

Behaviour:
- State encodings: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- Reset values: core_state=IDLE, current_pc=0, done=0, diverged=0. Reset asserted in any state aborts the block and returns to these values on the next edge.
- IDLE:
  - start=1 and thread_enable≠0 → FETCH.
  - start=1 and thread_enable=0 → DONE; no fetch is issued.
  - Otherwise hold.
- FETCH: hold until fetch_done=1, then → DECODE. current_pc is stable throughout FETCH.
- DECODE: exactly 1 cycle, then → REQUEST. The decoder latches on this cycle.
- REQUEST: exactly 1 cycle, then → WAIT. LSUs latch requests on this cycle.
- WAIT:
  - Each cycle, busy = OR over enabled threads of (lsu_state==REQUESTING or lsu_state==WAITING).
  - busy=1 → stay. busy=0 → EXECUTE.
  - Disabled threads are ignored.
  - A non-memory instruction therefore spends exactly 1 cycle in WAIT.
- EXECUTE: exactly 1 cycle, then → UPDATE.
- UPDATE:
  - decoded_ret=1 → DONE; current_pc is unchanged.
  - Otherwise → FETCH, and current_pc ← next_pc of the lowest-indexed enabled thread.
  - If any other enabled thread's next_pc differs, diverged is set. It stays set until reset.
- DONE: done=1 and the state holds until reset; start is ignored.
- done is combinational on core_state==DONE and is never 1 outside DONE.
- PC arithmetic: no increment inside this block. PC units supply next_pc. Wrap is their responsibility, and the value is taken verbatim.
- Minimum instruction latency without memory: 6 cycles (FETCH with immediate fetch_done, DECODE, REQUEST, WAIT, EXECUTE, UPDATE).
- thread_enable changes mid-block are sampled each cycle. They are legal only in IDLE; behaviour otherwise is unspecified but must not deadlock the FSM.

Decomposition:
- Package gpu_core_pkg holds:
  - core_state_t enum (8 encodings above)
  - lsu_state_t enum (IDLE, REQUESTING, WAITING, DONE)
  - CORE_STATE_DECODE constant, shared with the decoder
- Sub-module pc_select is combinational:
  - priority-select of the lowest enabled thread's next_pc
  - mismatch flag over the remaining enabled threads
  - Instantiated once in core_sequencer.

Test Plan:
- ALU instruction, THREADS=4, mask=1111, fetch_done 2 cycles after FETCH entry, all next_pc=5 → state trace 001,001,010,011,100,101,110,001; current_pc=5; diverged=0.
- LDR, thread 2 lsu_state REQUESTING 1 cycle then WAITING 3 cycles then DONE → WAIT occupies 5 cycles, then EXECUTE.
- Disabled-thread ignore: mask=0101, thread 1 lsu_state stuck WAITING → WAIT lasts 1 cycle; next_pc of thread 1 = 9, threads 0/2 = 3 → current_pc=3, diverged=0.
- Divergence: mask=1111, next_pc={7,7,4,7} (thread 0 first) → current_pc=7, diverged=1, and it stays 1 across later UPDATEs.
- RET in UPDATE → DONE, done=1, current_pc unchanged; start toggles produce no state change.
- Boundaries:
  - start with mask=0000 → DONE next cycle, no FETCH.
  - Reset asserted during WAIT → next cycle core_state=000, current_pc=0, done=0, diverged=0.
